// File: rtl/nn_parameters.sv
// Shared network-wide constants and the common signed data type.
package nn_parameters;

  localparam int unsigned OUT_SIZE_1 = 128;
  localparam int unsigned DATA_W     = 24;

  typedef logic signed [DATA_W-1:0] nn_data_t;

endpackage

// File: rtl/vector_stream_reader.sv
// vector_stream_reader: captures a full parallel layer vector on start and
// streams it out one element per valid/ready transfer.
// Optional build macro: VECTOR_STREAM_READER_RELU_EN clamps negative elements
// to zero on the read path (the captured buffer itself is never modified).
module vector_stream_reader
  import nn_parameters::*;
#(
  parameter int unsigned VEC_SIZE = OUT_SIZE_1,
  parameter int unsigned DATA_W   = nn_parameters::DATA_W,
  localparam int unsigned IDX_W   = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_vector [VEC_SIZE],
  output logic                     busy,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_valid;
  logic                      r_last;
  logic                      r_busy;
  logic                      r_done;
  logic signed [DATA_W-1:0]  r_buf [VEC_SIZE];

  logic                      w_capture;
  logic                      w_xfer;
  logic                      w_at_last;
  logic [IDX_W-1:0]          w_idx_next;
  logic signed [DATA_W-1:0]  w_elem;

  assign w_capture  = (r_state == S_IDLE) && start;
  assign w_xfer     = r_valid && out_ready;
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_idx_next = r_idx + IDX_W'(1);

  // Vector buffer: cleared on reset, loaded only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < VEC_SIZE; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      for (int unsigned i = 0; i < VEC_SIZE; i++) begin
        r_buf[i] <= input_vector[i];
      end
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_STREAM;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= (LAST_IDX == '0);
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_at_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= w_idx_next;
              r_last <= (w_idx_next == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read path: select the current element from the registered buffer.
  always_comb begin
    w_elem = r_buf[r_idx];
`ifdef VECTOR_STREAM_READER_RELU_EN
    out_data = w_elem[DATA_W-1] ? '0 : w_elem;
`else
    out_data = w_elem;
`endif
  end

  assign out_index = r_idx;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vector_stream_reader.sv
// Directed self-checking bench for vector_stream_reader.
// Honours VECTOR_STREAM_READER_RELU_EN for the expected read-path values.
module tb_vector_stream_reader;

  localparam int N = 128;
  localparam int W = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] vin  [N];
  logic signed [W-1:0] expv [N];
  logic                busy;
  logic signed [W-1:0] out_data;
  logic [6:0]          out_index;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                done;

  int total = 0;
  int bad   = 0;

  vector_stream_reader #(.VEC_SIZE(N), .DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .input_vector (vin),
    .busy         (busy),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [W-1:0] read_path(input logic signed [W-1:0] v);
`ifdef VECTOR_STREAM_READER_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic set_expected();
    for (int i = 0; i < N; i++) expv[i] = read_path(vin[i]);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the capture edge.
  task automatic capture();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"},  32'(out_last),  0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_data"},  32'(out_data),  0);
    chk({tag, "_index"}, 32'(out_index), 0);
  endtask

  // Consume the stream from the current negedge; optional stall toggling,
  // a start pulse mid-stream, or an asynchronous reset at element abort_at.
  task automatic stream(input string tag, input bit toggle, input int reassert_at, input int abort_at);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k < N && cyc < 600) begin
      if (k == abort_at) begin
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check_idle_zero({tag, "_abort"});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_abort_nodone"}, 32'(done), 0);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero({tag, "_after_abort"});
        return;
      end
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_busy"},  32'(busy),      1);
      chk({tag, "_data"},  32'(out_data),  32'(expv[k]));
      chk({tag, "_index"}, 32'(out_index), k);
      chk({tag, "_last"},  32'(out_last),  (k == N - 1) ? 1 : 0);
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      out_ready = rdy;
      start = (cyc == reassert_at);
      if (cyc == reassert_at) for (int i = 0; i < N; i++) vin[i] = -24'sd5000 - W'(i);
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_cycles"}, cyc, toggle ? 2 * N - 1 : N);
    chk({tag, "_end_valid"}, 32'(out_valid), 0);
    chk({tag, "_end_done"},  32'(done),      1);
    chk({tag, "_end_busy"},  32'(busy),      1);
    @(negedge clk);
    chk({tag, "_idle_done"}, 32'(done),      0);
    chk({tag, "_idle_busy"}, 32'(busy),      0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) vin[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Ascending vector, consumer always ready.
    for (int i = 0; i < N; i++) vin[i] = W'(i + 1);
    set_expected();
    capture();
    stream("seq", 1'b0, -1, -1);

    // Ready in IDLE has no effect; then alternating stalls with mixed signs.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready_valid", 32'(out_valid), 0);
    chk("idle_ready_busy",  32'(busy),      0);
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) vin[i] = W'(i * 3) - 24'sd200;
    set_expected();
    capture();
    stream("toggle", 1'b1, -1, -1);

    // Input changes after capture and a start pulse mid-stream are ignored.
    for (int i = 0; i < N; i++) vin[i] = W'(i * 7 + 11);
    set_expected();
    capture();
    for (int i = 0; i < N; i++) vin[i] = W'(i * 13) - 24'sd900;
    stream("hold", 1'b0, 10, -1);

    // Sign handling on the read path.
    for (int i = 0; i < N; i++) vin[i] = '0;
    vin[5] = 24'hFFFFF6;
    vin[6] = 24'h00000A;
    vin[N-1] = 24'h800000;
    set_expected();
    capture();
    stream("sign", 1'b0, -1, -1);

    // Asynchronous reset at element 40, then a clean stream afterwards.
    for (int i = 0; i < N; i++) vin[i] = W'(i + 1);
    set_expected();
    capture();
    stream("abort", 1'b0, -1, 40);
    for (int i = 0; i < N; i++) vin[i] = W'(N - i);
    set_expected();
    capture();
    stream("recover", 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
